// File: rtl/bit_serial_adder.sv
// Bit-serial ripple adder. Operands are latched on an input handshake and one
// sum bit is produced per clock, LSB first. The result is held until the consumer takes it.
// Ports: clk/rst (async active-high), in_valid/in_ready + a, b, c operands,
//        out_valid/out_ready + sum, carry result.
// Latency: out_valid is first high in the cycle after edge E0+WIDTH (E0 = input handshake).
// Backpressure: the result is held in HOLD until out_ready; in_ready is low until then.
module bit_serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             carry
);

    // The counter only needs to reach WIDTH-1. It is kept at least 1 bit wide so WIDTH=1 elaborates.
    localparam int            CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] HOLD = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             cr_q, cr_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             carry_q, carry_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    logic             s_bit;
    logic             c_bit;
    logic [WIDTH:0]   sum_cat;

    // Full adder on the current LSBs of the operand shift registers.
    assign s_bit   = a_q[0] ^ b_q[0] ^ cr_q;
    assign c_bit   = (a_q[0] & b_q[0]) | (a_q[0] & cr_q) | (b_q[0] & cr_q);
    // The new bit enters at the MSB. After WIDTH shifts, bit i is in sum[i].
    assign sum_cat = {s_bit, sum_q};

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        cr_d    = cr_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = b;
                    cr_d    = c;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                a_d   = a_q >> 1;
                b_d   = b_q >> 1;
                cr_d  = c_bit;
                sum_d = sum_cat[WIDTH:1];
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == LAST) begin
                    // The carry output updates only here. It keeps its last value through IDLE and the next RUN.
                    carry_d = c_bit;
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            cr_q    <= 1'b0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            cr_q    <= cr_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == HOLD);
    assign sum       = sum_q;
    assign carry     = carry_q;

endmodule

// File: tb/tb_bit_serial_adder.sv
// Scoreboard bench for bit_serial_adder: one WIDTH=8 and one WIDTH=1 instance.
// Drivers push arithmetic expectations on each handshake and monitors pop on out_valid&&out_ready.
module tb_bit_serial_adder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       iv8, ir8, ov8, or8, c8, co8;
    logic [7:0] a8, b8, s8;
    logic       iv1, ir1, ov1, or1, c1, co1;
    logic [0:0] a1, b1, s1;

    bit_serial_adder #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(ir8), .a(a8), .b(b8), .c(c8),
        .out_valid(ov8), .out_ready(or8), .sum(s8), .carry(co8)
    );

    bit_serial_adder #(.WIDTH(1)) dut1 (
        .clk(clk), .rst(rst), .in_valid(iv1), .in_ready(ir1), .a(a1), .b(b1), .c(c1),
        .out_valid(ov1), .out_ready(or1), .sum(s1), .carry(co1)
    );

    typedef struct {
        logic [7:0] sum;
        logic       carry;
        int         hs;
    } exp_t;

    exp_t q8[$];
    exp_t q1[$];
    int   cyc = 0;
    int   n_chk = 0;
    int   n_pass = 0;
    logic pv8, pv1;
    logic rnd_bp;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Called just after a rising edge. Holds the operands until accepted.
    task automatic send8(input logic [7:0] a, input logic [7:0] b, input logic c);
        int         t;
        exp_t       e;
        logic [8:0] tot;
        t = 0;
        iv8 = 1'b1; a8 = a; b8 = b; c8 = c;
        while (!ir8 && t < 200) begin
            @(posedge clk); #1; t++;
        end
        if (!ir8) begin
            chk("send8_timeout", 32'(ir8), 32'd1);
            iv8 = 1'b0;
            return;
        end
        tot     = {1'b0, a} + {1'b0, b} + {8'b0, c};
        e.sum   = tot[7:0];
        e.carry = tot[8];
        e.hs    = cyc + 1;
        q8.push_back(e);
        @(posedge clk); #1;
        iv8 = 1'b0;
        chk("in_ready8_run", 32'(ir8), 32'd0);
    endtask

    task automatic send1(input logic a, input logic b, input logic c);
        int         t;
        exp_t       e;
        logic [1:0] tot;
        t = 0;
        iv1 = 1'b1; a1 = a; b1 = b; c1 = c;
        while (!ir1 && t < 50) begin
            @(posedge clk); #1; t++;
        end
        if (!ir1) begin
            chk("send1_timeout", 32'(ir1), 32'd1);
            iv1 = 1'b0;
            return;
        end
        tot     = {1'b0, a} + {1'b0, b} + {1'b0, c};
        e.sum   = {7'b0, tot[0]};
        e.carry = tot[1];
        e.hs    = cyc + 1;
        q1.push_back(e);
        @(posedge clk); #1;
        iv1 = 1'b0;
        chk("in_ready1_run", 32'(ir1), 32'd0);
    endtask

    task automatic drain();
        int t;
        t = 0;
        while ((q8.size() != 0 || q1.size() != 0 || !ir8 || !ir1) && t < 500) begin
            @(posedge clk); #1; t++;
        end
        chk("drain_q8", 32'(q8.size()), 32'd0);
        chk("drain_q1", 32'(q1.size()), 32'd0);
    endtask

    // Monitors compare every cycle a result is presented, so a result that changes while stalled is caught.
    always @(negedge clk) begin
        if (rst) begin
            pv8 <= 1'b0;
        end else begin
            if (ov8) begin
                if (q8.size() == 0) begin
                    chk("ov8_unexpected", 32'(ov8), 32'd0);
                end else begin
                    if (!pv8) chk("latency8", 32'(cyc), 32'(q8[0].hs + 8));
                    chk("sum8", 32'(s8), 32'(q8[0].sum));
                    chk("carry8", 32'(co8), 32'(q8[0].carry));
                    if (or8) void'(q8.pop_front());
                end
            end
            pv8 <= ov8;
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            pv1 <= 1'b0;
        end else begin
            if (ov1) begin
                if (q1.size() == 0) begin
                    chk("ov1_unexpected", 32'(ov1), 32'd0);
                end else begin
                    if (!pv1) chk("latency1", 32'(cyc), 32'(q1[0].hs + 1));
                    chk("sum1", 32'(s1), 32'(q1[0].sum[0]));
                    chk("carry1", 32'(co1), 32'(q1[0].carry));
                    if (or1) void'(q1.pop_front());
                end
            end
            pv1 <= ov1;
        end
    end

    initial begin
        int t;
        rst = 1'b1;
        iv8 = 1'b0; a8 = '0; b8 = '0; c8 = 1'b0; or8 = 1'b1;
        iv1 = 1'b0; a1 = '0; b1 = '0; c1 = 1'b0; or1 = 1'b1;
        rnd_bp = 1'b0;
        #1;
        chk("rst_in_ready8", 32'(ir8), 32'd1);
        chk("rst_out_valid8", 32'(ov8), 32'd0);
        chk("rst_sum8", 32'(s8), 32'd0);
        chk("rst_carry8", 32'(co8), 32'd0);
        chk("rst_in_ready1", 32'(ir1), 32'd1);
        chk("rst_out_valid1", 32'(ov1), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // A zero operand pair is sent immediately after reset release.
        send8(8'h00, 8'h00, 1'b0);
        send8(8'hFF, 8'h01, 1'b0);
        send8(8'hFF, 8'hFF, 1'b1);

        // Full-adder truth table on the 1-bit instance.
        for (int i = 0; i < 8; i++) begin
            logic [2:0] v;
            v = 3'(i);
            send1(v[2], v[1], v[0]);
        end
        drain();

        // Backpressure: the result must stay stable while stalled.
        or8 = 1'b0;
        send8(8'h5A, 8'h3C, 1'b0);
        t = 0;
        while (!ov8 && t < 50) begin
            @(posedge clk); #1; t++;
        end
        chk("bp_out_valid", 32'(ov8), 32'd1);
        repeat (5) @(posedge clk);
        #1 or8 = 1'b1;
        @(posedge clk); #1;
        chk("bp_in_ready", 32'(ir8), 32'd1);
        chk("bp_out_valid_fall", 32'(ov8), 32'd0);
        chk("bp_sum_kept", 32'(s8), 32'h96);

        // The second request keeps in_valid high during the first run.
        send8(8'h20, 8'h30, 1'b0);
        send8(8'h11, 8'h00, 1'b0);
        drain();

        // Reset is applied mid-run. No result may appear.
        send8(8'hAA, 8'h55, 1'b0);
        void'(q8.pop_back());
        @(posedge clk); @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_sum", 32'(s8), 32'd0);
        chk("mid_rst_carry", 32'(co8), 32'd0);
        chk("mid_rst_out_valid", 32'(ov8), 32'd0);
        chk("mid_rst_in_ready", 32'(ir8), 32'd1);
        @(posedge clk); #1 rst = 1'b0;
        send8(8'h01, 8'h01, 1'b0);
        drain();

        // Random operands with random consumer stalls.
        rnd_bp = 1'b1;
        fork
            begin
                for (int i = 0; i < 40; i++) begin
                    send8(8'($urandom), 8'($urandom), 1'($urandom));
                    if (i % 4 == 0) send1(1'($urandom), 1'($urandom), 1'($urandom));
                end
                rnd_bp = 1'b0;
            end
            begin
                while (rnd_bp) begin
                    @(posedge clk); #1;
                    or8 = 1'($urandom_range(0, 1));
                    or1 = 1'($urandom_range(0, 1));
                end
            end
        join
        or8 = 1'b1;
        or1 = 1'b1;
        drain();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
